// File: rtl/fpm_array.sv
// Array floating-point multiplier: DEPTH operand pairs in, DEPTH IEEE-754 single products out.
// Rounding build option: define FPM_RNE_EN for round-to-nearest-even, otherwise truncation.
//
// state   | meaning
// IDLE    | waiting for start, load port open
// FETCH   | read operand pair at index
// UNPACK  | split fields, classify operands, seed the multiplier
// MUL     | 24-step shift-and-add over mant_b
// NORM    | normalise, round, select special results
// WRITE   | store product at index, advance index
// DONE    | all pairs processed, load port open
module fpm_array #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_a,
  input  logic [31:0]       ld_b,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] ram_addr_juiz,
  output logic [31:0]       ram_out_juiz,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_UNPACK, S_MUL, S_NORM, S_WRITE, S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t state, next;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [31:0] res_mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   cnt_q, cnt_clamped;
  logic [31:0]       op_a, op_b, res_q;
  logic              sign_q, any_nan, inf_zero, any_inf, any_zero;
  logic signed [9:0] exp_q;
  logic [23:0]       mb_q;
  logic [47:0]       mcand_q, acc_q;
  logic [4:0]        step_q;
  logic              open_port, accept, last;

  assign open_port   = (state == S_IDLE) || (state == S_DONE);
  assign accept      = start && open_port;
  assign cnt_clamped = (count > DEPTH_C) ? DEPTH_C : count;
  assign last        = ({1'b0, idx} == (cnt_q - ONE_C));
  assign ram_out_juiz = res_mem[ram_addr_juiz];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_DONE: if (accept) next = (cnt_clamped == '0) ? S_DONE : S_FETCH;
      S_FETCH:        next = S_UNPACK;
      S_UNPACK:       next = S_MUL;
      S_MUL:          if (step_q == 5'd0) next = S_NORM;
      S_NORM:         next = S_WRITE;
      S_WRITE:        next = last ? S_DONE : S_FETCH;
      default:        next = S_IDLE;
    endcase
  end

  // operand field extraction; exp = 0 is flushed to zero, denormals included
  logic [7:0]        ea, eb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [23:0]       ma, mb;
  logic signed [9:0] exp_sum;

  always_comb begin
    ea      = op_a[30:23];
    eb      = op_b[30:23];
    a_nan   = (ea == 8'hFF) && (op_a[22:0] != '0);
    b_nan   = (eb == 8'hFF) && (op_b[22:0] != '0);
    a_inf   = (ea == 8'hFF) && (op_a[22:0] == '0);
    b_inf   = (eb == 8'hFF) && (op_b[22:0] == '0);
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    ma      = a_zero ? 24'd0 : {1'b1, op_a[22:0]};
    mb      = b_zero ? 24'd0 : {1'b1, op_b[22:0]};
    exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
  end

  logic [22:0]       frac;
  logic signed [9:0] e1, e2;
  logic              rnd;
  logic [23:0]       rounded;
  logic [31:0]       result;

  always_comb begin
    if (acc_q[47]) begin
      frac = acc_q[46:24];
      e1   = exp_q + 10'sd1;
    end else begin
      frac = acc_q[45:23];
      e1   = exp_q;
    end
`ifdef FPM_RNE_EN
    if (acc_q[47]) rnd = acc_q[23] & ((|acc_q[22:0]) | frac[0]);
    else           rnd = acc_q[22] & ((|acc_q[21:0]) | frac[0]);
`else
    rnd = 1'b0;
`endif
    // a carry out leaves the fraction at zero, i.e. 1.0 at the next exponent
    rounded = {1'b0, frac} + {23'd0, rnd};
    e2      = e1 + $signed({9'd0, rounded[23]});
    if (any_nan || inf_zero) result = 32'h7FC00000;
    else if (any_inf)        result = {sign_q, 31'h7F800000};
    else if (any_zero)       result = {sign_q, 31'h0};
    else if (e2 >= 10'sd255) result = {sign_q, 31'h7F800000};
    else if (e2 <= 10'sd0)   result = {sign_q, 31'h0};
    else                     result = {sign_q, e2[7:0], rounded[22:0]};
  end

  always_ff @(posedge clock) begin
    if (ld_we && open_port) begin
      mem_a[ld_addr] <= ld_a;
      mem_b[ld_addr] <= ld_b;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      idx      <= '0;
      cnt_q    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      any_nan  <= 1'b0;
      inf_zero <= 1'b0;
      any_inf  <= 1'b0;
      any_zero <= 1'b0;
      mb_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      res_q    <= '0;
      for (int i = 0; i < DEPTH; i++) res_mem[i] <= '0;
    end else begin
      busy <= (state != S_IDLE) && (state != S_DONE);
      done <= accept ? 1'b0 : (state == S_DONE);
      if (accept) begin
        cnt_q <= cnt_clamped;
        idx   <= '0;
      end
      case (state)
        S_FETCH: begin
          op_a <= mem_a[idx];
          op_b <= mem_b[idx];
        end
        S_UNPACK: begin
          sign_q   <= op_a[31] ^ op_b[31];
          exp_q    <= exp_sum;
          any_nan  <= a_nan || b_nan;
          inf_zero <= (a_inf && b_zero) || (b_inf && a_zero);
          any_inf  <= a_inf || b_inf;
          any_zero <= a_zero || b_zero;
          acc_q    <= '0;
          mcand_q  <= {24'd0, ma};
          mb_q     <= mb;
          step_q   <= 5'd23;
        end
        S_MUL: begin
          if (mb_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q <= mcand_q << 1;
          mb_q    <= mb_q >> 1;
          step_q  <= step_q - 5'd1;
        end
        S_NORM:  res_q <= result;
        S_WRITE: begin
          res_mem[idx] <= res_q;
          idx          <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpm_array.sv
// Directed bench for fpm_array: a 4-entry instance for arithmetic/timing and an
// 8-entry instance for count clamping and mid-run start/load immunity.
module tb_fpm_array;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        ld_we4 = 0, start4 = 0;
  logic [1:0]  ld_addr4 = 0, raddr4 = 0;
  logic [31:0] ld_a4 = 0, ld_b4 = 0, rdata4;
  logic [2:0]  count4 = 0;
  logic        busy4, done4;

  logic        ld_we8 = 0, start8 = 0;
  logic [2:0]  ld_addr8 = 0, raddr8 = 0;
  logic [31:0] ld_a8 = 0, ld_b8 = 0, rdata8;
  logic [3:0]  count8 = 0;
  logic        busy8, done8;

  int pass_cnt = 0;
  int total_cnt = 0;

  fpm_array #(.DEPTH(4), .ADDR_W(2)) u_dut4 (
    .clock(clock), .reset(reset), .ld_we(ld_we4), .ld_addr(ld_addr4),
    .ld_a(ld_a4), .ld_b(ld_b4), .start(start4), .count(count4),
    .ram_addr_juiz(raddr4), .ram_out_juiz(rdata4), .busy(busy4), .done(done4)
  );

  fpm_array #(.DEPTH(8), .ADDR_W(3)) u_dut8 (
    .clock(clock), .reset(reset), .ld_we(ld_we8), .ld_addr(ld_addr8),
    .ld_a(ld_a8), .ld_b(ld_b8), .start(start8), .count(count8),
    .ram_addr_juiz(raddr8), .ram_out_juiz(rdata8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic load4(input logic [1:0] a, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clock);
    ld_we4 = 1; ld_addr4 = a; ld_a4 = va; ld_b4 = vb;
    @(negedge clock);
    ld_we4 = 0;
  endtask

  task automatic read4(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clock);
    raddr4 = a;
    #1 chk(tag, rdata4, exp);
  endtask

  // start at edge T, then count edges until done is seen just after an edge
  task automatic go4(input string tag, input logic [2:0] c, input int exp_n);
    int n;
    n = -1;
    @(negedge clock);
    start4 = 1; count4 = c;
    @(posedge clock);
    #1 start4 = 0;
    chk({tag, "_busy_T"}, {31'd0, busy4}, 32'd0);
    chk({tag, "_done_T"}, {31'd0, done4}, 32'd0);
    for (int i = 1; i <= 400; i++) begin
      @(posedge clock);
      #1;
      if (i == 1) chk({tag, "_busy_T1"}, {31'd0, busy4}, {31'd0, c != 0});
      if (done4) begin n = i; break; end
    end
    chk({tag, "_done_cyc"}, n, exp_n);
    chk({tag, "_busy_end"}, {31'd0, busy4}, 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_done", {31'd0, done4}, 32'd0);
    chk("rst_res3", rdata4, 32'd0);
    reset = 0;

    load4(0, 32'h40000000, 32'h40400000);
    load4(1, 32'h3FC00000, 32'h3FC00000);
    go4("run1", 3'd2, 57);
    read4("r1_e0", 0, 32'h40C00000);
    read4("r1_e1", 1, 32'h40100000);

    load4(0, 32'h7F000000, 32'h7F000000);
    load4(1, 32'h00000000, 32'hC0000000);
    load4(2, 32'h00800000, 32'h00800000);
    load4(3, 32'h7FC00000, 32'h3F800000);
    go4("run2", 3'd4, 113);
    read4("ovf_inf", 0, 32'h7F800000);
    read4("neg_zero", 1, 32'h80000000);
    read4("undflow", 2, 32'h00000000);
    read4("nan_in", 3, 32'h7FC00000);

    load4(0, 32'h7F800000, 32'h00000000);
    load4(1, 32'hFF800000, 32'h40000000);
    load4(2, 32'h3F800001, 32'h3FC00000);
    go4("run3", 3'd3, 85);
    read4("inf_x_zero", 0, 32'h7FC00000);
    read4("neg_inf", 1, 32'hFF800000);
`ifdef FPM_RNE_EN
    read4("round", 2, 32'h3FC00002);
`else
    read4("round", 2, 32'h3FC00001);
`endif
    read4("kept_old", 3, 32'h7FC00000);

    go4("cnt0", 3'd0, 1);

    // reset during MUL of entry 1
    @(negedge clock);
    start4 = 1; count4 = 3'd2;
    @(posedge clock);
    #1 start4 = 0;
    repeat (38) @(posedge clock);
    #1 reset = 1;
    #1;
    chk("mid_rst_done", {31'd0, done4}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy4}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      raddr4 = 2'(i);
      #1 chk("mid_rst_res", rdata4, 32'd0);
    end
    @(negedge clock);
    reset = 0;
    go4("after_rst", 3'd1, 29);
    read4("ar_e0", 0, 32'h7FC00000);
    read4("ar_e1", 1, 32'h00000000);

    // 8-entry instance: 2.0 * 2^i = 2^(i+1)
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      ld_we8 = 1; ld_addr8 = 3'(i); ld_a8 = 32'h40000000; ld_b8 = (32'd127 + i) << 23;
    end
    @(negedge clock);
    ld_we8 = 0;
    start8 = 1; count8 = 4'd9;
    @(posedge clock);
    #1 start8 = 0;
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clock);
      #1;
      if (i == 50) begin
        start8 = 1; count8 = 4'd1;
        ld_we8 = 1; ld_addr8 = 3'd7; ld_a8 = 32'h0; ld_b8 = 32'h0;
      end
      if (i == 51) begin start8 = 0; ld_we8 = 0; end
      if (i == 100) chk("d8_busy_mid", {31'd0, busy8}, 32'd1);
      if (done8) begin n = i; break; end
    end
    chk("d8_done_cyc", n, 225);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      raddr8 = 3'(i);
      #1 chk("d8_res", rdata8, (32'd128 + i) << 23);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
